matrix_3x3_gen: RTL and testbench

//  Builds a 3x3 pixel window from a raster 8-bit pixel stream for the 3x3 kernels (median, sobel, ...).

---
 rtl/img_pkg.sv | 15 +
 rtl/line_buf_ram.sv | 27 ++
 rtl/matrix_3x3_gen.sv | 185 ++++++++++++++++++
 tb/tb_matrix_3x3_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default geometry and the line counter type.
package img_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 1280;
  localparam int ADDR_W_DEF = 11;

  // Lines seen in the current frame, saturating at 2 (enough to unmask all rows).
  typedef logic [1:0] line_cnt_t;

  function automatic line_cnt_t line_inc(input line_cnt_t l);
    return (l == 2'd2) ? l : l + 2'd1;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Simple dual-port RAM with a registered read port; a read of the address being
// written in the same cycle returns the previous content.
module line_buf_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1280,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port and registered read port; content is never cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 window generator for raster pixel streams. One RAM word per column holds
// {line n-2, line n-1}; reading it and writing back {line n-1, new pixel} one
// clock later shifts the stored rows down a line. Borders are zero-padded.
module matrix_3x3_gen
  import img_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync_in,
  input  logic              hsync_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data11,
  output logic [DATA_W-1:0] data12,
  output logic [DATA_W-1:0] data13,
  output logic [DATA_W-1:0] data21,
  output logic [DATA_W-1:0] data22,
  output logic [DATA_W-1:0] data23,
  output logic [DATA_W-1:0] data31,
  output logic [DATA_W-1:0] data32,
  output logic [DATA_W-1:0] data33,
  output logic              vsync_out,
  output logic              hsync_out,
  output logic              de_out
);

  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 1);

  // Column / line tracking
  logic [ADDR_W-1:0] r_col;
  logic              r_ovf;       // current line already ran past the last column
  line_cnt_t         r_line;
  logic              r_eol_pend;  // de fell; line ends if hsync comes before de returns
  logic              r_vs_prev;
  logic              r_de_prev;

  logic              w_vs_rise;
  logic              w_de_fall;
  logic              w_eol;
  logic [ADDR_W-1:0] w_col;
  logic              w_ovf;
  line_cnt_t         w_line;

  // Stage 1 registers
  logic              r_vs_d1, r_hs_d1, r_de_d1;
  logic [DATA_W-1:0] r_data_d1;
  logic [ADDR_W-1:0] r_col_d1;
  logic              r_wr_ok_d1;
  line_cnt_t         r_line_d1;

  // Stage 2 registers
  logic              r_vs_d2, r_hs_d2, r_de_d2;
  logic [DATA_W-1:0] r_win [1:3][1:3];

  logic [2*DATA_W-1:0] w_rd;
  logic [DATA_W-1:0]   w_tap [1:3];

  assign w_vs_rise = vsync_in & ~r_vs_prev;
  assign w_de_fall = ~de_in & r_de_prev;
  assign w_eol     = r_eol_pend & hsync_in;
  // A vsync edge overrides a line end landing in the same cycle.
  assign w_col     = (w_vs_rise | w_eol) ? '0   : r_col;
  assign w_ovf     = (w_vs_rise | w_eol) ? 1'b0 : r_ovf;
  assign w_line    = w_vs_rise ? '0 : (w_eol ? line_inc(r_line) : r_line);

  // Column counter, overflow flag, line counter and line-end detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_ovf      <= 1'b0;
      r_line     <= '0;
      r_eol_pend <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_de_prev  <= 1'b0;
    end else begin
      r_vs_prev <= vsync_in;
      r_de_prev <= de_in;
      r_line    <= w_line;
      if (de_in) begin
        if (w_ovf || (w_col == COL_MAX)) begin
          r_col <= w_col;
          r_ovf <= 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_ovf <= 1'b0;
        end
      end else begin
        r_col <= w_col;
        r_ovf <= w_ovf;
      end
      if (w_vs_rise || de_in) r_eol_pend <= 1'b0;
      else if (w_de_fall)     r_eol_pend <= 1'b1;
      else if (w_eol)         r_eol_pend <= 1'b0;
    end
  end

  // ---- stage 1: RAM read at the current column, input register ----
  line_buf_ram #(
    .WIDTH (2*DATA_W),
    .DEPTH (IMG_W),
    .AW    (ADDR_W)
  ) u_line_buf (
    .clk       (clk),
    .i_wr_en   (r_de_d1 & r_wr_ok_d1),
    .i_wr_addr (r_col_d1),
    .i_wr_data ({w_rd[DATA_W-1:0], r_data_d1}),
    .i_rd_addr (w_col),
    .o_rd_data (w_rd)
  );

  // Delay the beat, its column and line position alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d1    <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_de_d1    <= 1'b0;
      r_data_d1  <= '0;
      r_col_d1   <= '0;
      r_wr_ok_d1 <= 1'b0;
      r_line_d1  <= '0;
    end else begin
      r_vs_d1    <= vsync_in;
      r_hs_d1    <= hsync_in;
      r_de_d1    <= de_in;
      r_data_d1  <= data_in;
      r_col_d1   <= w_col;
      r_wr_ok_d1 <= ~w_ovf;
      r_line_d1  <= w_line;
    end
  end

  // ---- stage 2: row masking and window shift ----
  // Rows that do not exist yet in this frame read as zero.
  always_comb begin
    w_tap[3] = r_data_d1;
    w_tap[2] = (r_line_d1 != 2'd0) ? w_rd[DATA_W-1:0]        : '0;
    w_tap[1] = (r_line_d1 == 2'd2) ? w_rd[2*DATA_W-1:DATA_W] : '0;
  end

  // Shift each row left on a beat; the first beat of a line pads the left columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r <= 3; r++)
        for (int c = 1; c <= 3; c++)
          r_win[r][c] <= '0;
    end else if (r_de_d1) begin
      for (int r = 1; r <= 3; r++) begin
        r_win[r][1] <= (r_col_d1 == '0) ? '0 : r_win[r][2];
        r_win[r][2] <= (r_col_d1 == '0) ? '0 : r_win[r][3];
        r_win[r][3] <= w_tap[r];
      end
    end
  end

  // Second sync delay stage, aligned with the window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d2 <= 1'b0;
      r_hs_d2 <= 1'b0;
      r_de_d2 <= 1'b0;
    end else begin
      r_vs_d2 <= r_vs_d1;
      r_hs_d2 <= r_hs_d1;
      r_de_d2 <= r_de_d1;
    end
  end

  assign data11    = r_win[1][1];
  assign data12    = r_win[1][2];
  assign data13    = r_win[1][3];
  assign data21    = r_win[2][1];
  assign data22    = r_win[2][2];
  assign data23    = r_win[2][3];
  assign data31    = r_win[3][1];
  assign data32    = r_win[3][2];
  assign data33    = r_win[3][3];
  assign vsync_out = r_vs_d2;
  assign hsync_out = r_hs_d2;
  assign de_out    = r_de_d2;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: a line-oriented model predicts every window from
// the pixels per line and per-column history, checked on every de_out beat.
module tb_matrix_3x3_gen;
  localparam int DW = 8;
  localparam int IW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync_in = 1'b0, hsync_in = 1'b0, de_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data11, data12, data13, data21, data22, data23, data31, data32, data33;
  logic vsync_out, hsync_out, de_out;

  always #5 clk = ~clk;

  matrix_3x3_gen #(.DATA_W(DW), .IMG_W(IW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .data_in(data_in),
    .data11(data11), .data12(data12), .data13(data13),
    .data21(data21), .data22(data22), .data23(data23),
    .data31(data31), .data32(data32), .data33(data33),
    .vsync_out(vsync_out), .hsync_out(hsync_out), .de_out(de_out)
  );

  // v[r*3+c]: r=0 row1 .. r=2 row3, c=0 oldest .. c=2 newest
  typedef struct packed { logic [8:0][7:0] v; logic [8:0] kn; } win_t;
  typedef struct packed { logic [2:0][7:0] v; logic [2:0] kn; } tap_t;

  win_t expq[$];
  tap_t taps[$];
  logic [7:0] h1 [IW];   // most recent pixel stored per column
  logic [7:0] h2 [IW];   // the one before it
  bit         k1 [IW];
  bit         k2 [IW];
  int mL = 0, mk = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cnt_in = 0, cnt_out = 0;
  bit out_seen = 0;
  bit cap_en = 0;
  int cap_n = 0;
  logic [8:0][7:0] cap [64];
  logic [2:0] sd1, sd2;

  wire [8:0][7:0] dw = {data33, data32, data31, data23, data22, data21, data13, data12, data11};

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0][7:0] mkwin(input int a, b, c, d, e, f, g, h, i);
    logic [8:0][7:0] w;
    w[0] = 8'(a); w[1] = 8'(b); w[2] = 8'(c);
    w[3] = 8'(d); w[4] = 8'(e); w[5] = 8'(f);
    w[6] = 8'(g); w[7] = 8'(h); w[8] = 8'(i);
    return w;
  endfunction

  // Reference delay line for the sync outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd1 <= '0;
      sd2 <= '0;
    end else begin
      sd1 <= {vsync_in, hsync_in, de_in};
      sd2 <= sd1;
    end
  end

  // Compare process
  initial begin
    win_t w;
    logic [71:0] m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_zero", {dw, vsync_out, hsync_out, de_out}, '0);
      end else begin
        chk("sync_align", {vsync_out, hsync_out, de_out}, sd2);
        if (de_out) begin
          out_seen = 1;
          cnt_out++;
          if (expq.size() == 0) begin
            chk("window_unexpected", 1, 0);
          end else begin
            w = expq.pop_front();
            m = '0;
            for (int i = 0; i < 9; i++) if (w.kn[i]) m[i*8 +: 8] = 8'hFF;
            chk("window", dw & m, w.v & m);
            if (cap_en && cap_n < 64) begin
              cap[cap_n] = dw;
              cap_n++;
            end
          end
        end else if (!out_seen) begin
          chk("idle_zero", dw, '0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    de_in = 0;
    repeat (n) tick();
  endtask

  // Predict the window for one pixel and drive it.
  task automatic beat(input logic [7:0] pix);
    tap_t t;
    win_t w;
    int idx;
    t = '0;
    w = '0;
    t.v[2] = pix; t.kn[2] = 1;
    if (mL >= 1) begin
      if (mk < IW && k1[mk]) begin t.v[1] = h1[mk]; t.kn[1] = 1; end
    end else t.kn[1] = 1;
    if (mL == 2) begin
      if (mk < IW && k2[mk]) begin t.v[0] = h2[mk]; t.kn[0] = 1; end
    end else t.kn[0] = 1;
    if (mk < IW) begin
      h2[mk] = h1[mk]; k2[mk] = k1[mk];
      h1[mk] = pix;    k1[mk] = 1;
    end
    taps.push_back(t);
    for (int c = 0; c < 3; c++) begin
      idx = mk - 2 + c;
      for (int r = 0; r < 3; r++) begin
        if (idx < 0) begin
          w.v[r*3+c] = '0;
          w.kn[r*3+c] = 1;
        end else begin
          w.v[r*3+c] = taps[idx].v[r];
          w.kn[r*3+c] = taps[idx].kn[r];
        end
      end
    end
    expq.push_back(w);
    mk++;
    cnt_in++;
    de_in = 1;
    data_in = pix;
    tick();
  endtask

  task automatic do_line(input int len, input int base, input bit gaps);
    hsync_in = 1; tick();
    hsync_in = 0; tick();
    for (int c = 0; c < len; c++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      beat(base >= 0 ? 8'(base + c) : 8'($urandom));
    end
    idle(2);
    if (mL < 2) mL++;
    mk = 0;
    taps.delete();
  endtask

  task automatic start_frame();
    vsync_in = 1; tick();
    vsync_in = 0; tick();
    mL = 0;
    mk = 0;
    taps.delete();
  endtask

  task automatic end_frame();
    idle(4);
    chk("de_count", cnt_out, cnt_in);
    cnt_in = 0;
    cnt_out = 0;
  endtask

  task automatic forget_state();
    expq.delete();
    taps.delete();
    mL = 0;
    mk = 0;
    for (int i = 0; i < IW; i++) begin k1[i] = 0; k2[i] = 0; end
    cnt_in = 0;
    cnt_out = 0;
    out_seen = 0;
  endtask

  initial begin
    forget_state();
    // Reset with random inputs
    repeat (5) begin
      {vsync_in, hsync_in, de_in} = 3'($urandom);
      data_in = 8'($urandom);
      tick();
    end
    {vsync_in, hsync_in, de_in} = '0;
    data_in = '0;
    rst_n = 1;
    tick();
    idle(3);

    // Directed 4x4 frame, pixel = 16*row + col
    cap_en = 1;
    cap_n = 0;
    start_frame();
    for (int r = 0; r < 4; r++) do_line(4, 16 * r, 0);
    end_frame();
    cap_en = 0;
    chk("cap_count", cap_n, 16);
    chk("l0_c2", cap[2],  mkwin(0, 0, 0,    0,  0,  0,    0,  1,  2));
    chk("l1_c0", cap[4],  mkwin(0, 0, 0,    0,  0,  0,    0,  0, 16));
    chk("l1_c3", cap[7],  mkwin(0, 0, 0,    1,  2,  3,   17, 18, 19));
    chk("l2_c2", cap[10], mkwin(0, 1, 2,   16, 17, 18,   32, 33, 34));
    chk("l3_c3", cap[15], mkwin(17, 18, 19, 33, 34, 35,  49, 50, 51));

    // Overlong lines followed by normal ones
    start_frame();
    do_line(10, -1, 0);
    do_line(8, -1, 0);
    do_line(10, -1, 1);
    do_line(6, -1, 1);
    end_frame();

    // Random frames
    repeat (6) begin
      start_frame();
      repeat ($urandom_range(2, 5)) do_line($urandom_range(1, 10), -1, 1);
      end_frame();
    end

    // Reset during line 2
    start_frame();
    do_line(6, -1, 0);
    do_line(6, -1, 0);
    hsync_in = 1; tick();
    hsync_in = 0; tick();
    beat(8'($urandom));
    beat(8'($urandom));
    rst_n = 0;
    #1;
    chk("async_reset", {dw, vsync_out, hsync_out, de_out}, '0);
    forget_state();
    repeat (3) begin
      {vsync_in, hsync_in, de_in} = 3'($urandom);
      data_in = 8'($urandom);
      tick();
    end
    {vsync_in, hsync_in, de_in} = '0;
    data_in = '0;
    rst_n = 1;
    idle(3);
    start_frame();
    repeat (3) do_line(7, -1, 1);
    end_frame();

    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
